lsu_writeback: RTL
==================

// Module: lsu_writeback
// PURPOSE
//  Memory + writeback stage of the 3-stage RV32I core; consumes the execute->memory pipeline register outputs.
//  Drives data-memory req/ack bus: store byte lanes, load align/sign-extend, writeback select to register file.
//  Asserts stall_o to freeze the execute->memory register and upstream stages while a memory access is in flight.
// PARAMETERS
//  DW    32  datapath/address width (bits); DW/8 byte lanes
//  REGW  5   register index width
// PORTS
//  clk_i         in   1       single clock, rising edge
//  rst_i         in   1       reset, synchronous, active-high
//  alu_out_m     in   DW      ALU result / effective address
//  write_data_m  in   DW      store data (rs2)
//  rd_m          in   REGW    destination register
//  pc_plus_4_m   in   DW      link value for JAL/JALR
//  reg_write_m   in   1       instruction writes rd
//  wb_sel_m      in   2       00 ALU, 01 load data, 10 pc+4, 11 ALU
//  mem_write_m   in   1       store instruction
//  opcode_m      in   7       load detected when 7'b0000011
//  func3_m       in   3       access size/sign
//  dmem_req_o    out  1       memory request
//  dmem_we_o     out  1       1 = store
//  dmem_addr_o   out  DW      word-aligned address {alu_out_m[DW-1:2],2'b00}
//  dmem_wdata_o  out  DW      lane-replicated store data
//  dmem_be_o     out  DW/8    byte enables
//  dmem_ack_i    in   1       access complete; rdata valid same cycle
//  dmem_rdata_i  in   DW      read word
//  stall_o       out  1       hold upstream pipeline
//  rf_we_o       out  1       register-file write enable
//  rf_waddr_o    out  REGW    write address (= rd_m)
//  rf_wdata_o    out  DW      write data
//  misalign_o    out  1       misaligned access flag (one cycle)
// BEHAVIOUR
//  - FSM states IDLE, WAIT, DONE. Sync reset -> IDLE, load_buf=0; while rst_i=1 all outputs 0.
//  - mem_op = load | mem_write_m. IDLE & mem_op & aligned: req=1, stall=1; ack same cycle -> DONE, else -> WAIT.
//  - WAIT: req=1, stall=1, address/data/be held from inputs (stable because stalled); ack -> DONE.
//  - ack: load_buf <= dmem_rdata_i. DONE: req=0, stall=0, writeback issued; next edge -> IDLE (never re-issues).
//  - Minimum memory-op latency 2 cycles (IDLE+DONE); non-memory ops 0 extra cycles, no stall.
//  - ack sampled only in IDLE-with-req or WAIT; ack in any other cycle is ignored.
//  - Store func3: 000 SB be=4'b0001<<addr[1:0], wdata={4{b}}; 001 SH be=4'b0011<<addr[1:0], wdata={2{h}}; else SW be=4'hF.
//  - Load func3: 000 LB, 001 LH, 100 LBU, 101 LHU: lane picked by addr[1:0], sign/zero-extended; others = LW.
//  - rf_we_o = reg_write_m & (rd_m!=0) & (non-mem op in IDLE, or load in DONE); stores never write rf.
//  - rf_wdata_o by wb_sel_m: 01 -> aligned load_buf, 10 -> pc_plus_4_m, 00/11 -> alu_out_m.
//  - Reset mid-access: FSM -> IDLE same edge, req drops, pending ack discarded.
// CONFIGURATION
//  LSU_MISALIGN_CHK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no request, no stall,
//    no rf write, misalign_o=1 for that single cycle (instruction retires as no-op).
//  Undefined: no check; low address bits used as lane select only (word ops use lane 0); misalign_o tied 0.
// STRUCTURE
//  Shared riscv_pkg: OPC_LOAD, F3_LB/LH/LW/LBU/LHU/SB/SH/SW, wb_sel_e (WB_ALU/WB_MEM/WB_PC4), lsu_state_e.
//  Sub-module lsu_load_align: combinational lane select + sign/zero extension (rdata, addr[1:0], func3 -> DW).
// TESTING
//  1 SW addr 0x104, data 0xDEADBEEF, ack 1st cycle -> be=4'hF, addr 0x104, stall 1 cycle, rf_we_o=0.
//  2 LB addr 0x103, rdata 0x80FF_0000, ack after 3 WAIT cycles -> stall 4 cycles, rf_wdata 0xFFFFFF80.
//  3 LHU addr 0x102, rdata 0x8001_1234 -> rf_wdata 0x00008001; LH same -> 0xFFFF8001.
//  4 SB addr 0x101 data 0x000000AB -> be=4'b0010, wdata 0xABABABAB; JAL wb_sel=10 pc+4=0x200 -> rf_wdata 0x200, no stall.
//  5 LW to rd=x0 -> access performed, rf_we_o=0; rst_i asserted in WAIT -> req=0 next cycle, later ack ignored.
//  6 LSU_MISALIGN_CHK_EN: LW addr 0x102 -> misalign_o=1 one cycle, no req, no stall; undefined -> req at 0x100.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types for the memory/writeback stage.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  // Loads and stores decode func3 differently; anything unlisted is a word access.
  function automatic acc_size_e access_size(input logic is_load, input logic [2:0] func3);
    acc_size_e sz;
    sz = SZ_WORD;
    if (is_load) begin
      case (func3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end else begin
      case (func3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the byte/half lane from the read word and sign/zero-extends it.
module lsu_load_align
  import riscv_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    addr_lo,
  input  logic [2:0]    func3,
  output logic [DW-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half-word lane follows addr[1] only, so an odd half address reads its enclosing half.
  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    case (func3)
      F3_LB:   data = {{(DW-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(DW-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(DW-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(DW-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_writeback.sv
// RV32I memory + writeback stage: req/ack data-memory handshake, store lanes, load align, rf writeback.
// Optional LSU_MISALIGN_CHK_EN turns misaligned half/word accesses into flagged no-ops.
module lsu_writeback
  import riscv_pkg::*;
#(
  parameter int DW   = 32,
  parameter int REGW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DW-1:0]     alu_out_m,
  input  logic [DW-1:0]     write_data_m,
  input  logic [REGW-1:0]   rd_m,
  input  logic [DW-1:0]     pc_plus_4_m,
  input  logic              reg_write_m,
  input  logic [1:0]        wb_sel_m,
  input  logic              mem_write_m,
  input  logic [6:0]        opcode_m,
  input  logic [2:0]        func3_m,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DW-1:0]     dmem_addr_o,
  output logic [DW-1:0]     dmem_wdata_o,
  output logic [DW/8-1:0]   dmem_be_o,
  input  logic              dmem_ack_i,
  input  logic [DW-1:0]     dmem_rdata_i,
  output logic              stall_o,
  output logic              rf_we_o,
  output logic [REGW-1:0]   rf_waddr_o,
  output logic [DW-1:0]     rf_wdata_o,
  output logic              misalign_o
);

  localparam int BW = DW / 8;

  lsu_state_e  state_reg;
  logic [DW-1:0] load_buf_reg;
  logic [DW-1:0] load_aligned;
  logic        is_load, mem_op, misaligned, issue, req;
  logic [1:0]  lane;
  acc_size_e   size;
  logic [BW-1:0] be_calc;
  logic [DW-1:0] wdata_calc;

  assign is_load = (opcode_m == OPC_LOAD);
  assign mem_op  = is_load | mem_write_m;
  assign lane    = alu_out_m[1:0];
  assign size    = access_size(is_load, func3_m);

`ifdef LSU_MISALIGN_CHK_EN
  assign misaligned = mem_op & (((size == SZ_HALF) & lane[0]) |
                                ((size == SZ_WORD) & (lane != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // A new access starts only from IDLE; DONE always falls back to IDLE so nothing re-issues.
  assign issue = (state_reg == LSU_IDLE) & mem_op & ~misaligned;
  assign req   = issue | (state_reg == LSU_WAIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= LSU_IDLE;
      load_buf_reg <= '0;
    end else begin
      case (state_reg)
        LSU_IDLE: begin
          if (issue) begin
            if (dmem_ack_i) begin
              load_buf_reg <= dmem_rdata_i;
              state_reg    <= LSU_DONE;
            end else begin
              state_reg <= LSU_WAIT;
            end
          end
        end
        LSU_WAIT: begin
          if (dmem_ack_i) begin
            load_buf_reg <= dmem_rdata_i;
            state_reg    <= LSU_DONE;
          end
        end
        default: state_reg <= LSU_IDLE;
      endcase
    end
  end

  lsu_load_align #(.DW(DW)) u_align (
    .rdata   (load_buf_reg),
    .addr_lo (lane),
    .func3   (func3_m),
    .data    (load_aligned)
  );

  always_comb begin
    case (size)
      SZ_BYTE: begin
        be_calc    = {{(BW-1){1'b0}}, 1'b1} << lane;
        wdata_calc = {BW{write_data_m[7:0]}};
      end
      SZ_HALF: begin
        be_calc    = {{(BW-2){1'b0}}, 2'b11} << lane;
        wdata_calc = {(DW/16){write_data_m[15:0]}};
      end
      default: begin
        be_calc    = '1;
        wdata_calc = write_data_m;
      end
    endcase
  end

  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    dmem_be_o    = '0;
    stall_o      = 1'b0;
    rf_we_o      = 1'b0;
    rf_waddr_o   = '0;
    rf_wdata_o   = '0;
    misalign_o   = 1'b0;
    if (!rst_i) begin
      dmem_req_o   = req;
      dmem_we_o    = req & mem_write_m;
      dmem_addr_o  = {alu_out_m[DW-1:2], 2'b00};
      dmem_wdata_o = wdata_calc;
      dmem_be_o    = req ? be_calc : '0;
      stall_o      = req;
      misalign_o   = (state_reg == LSU_IDLE) & misaligned;
      rf_we_o      = reg_write_m & (rd_m != '0) &
                     (((state_reg == LSU_IDLE) & ~mem_op) |
                      ((state_reg == LSU_DONE) & is_load));
      rf_waddr_o   = rd_m;
      case (wb_sel_m)
        WB_MEM:  rf_wdata_o = load_aligned;
        WB_PC4:  rf_wdata_o = pc_plus_4_m;
        default: rf_wdata_o = alu_out_m;
      endcase
    end
  end

endmodule
